game_timer_ctrl: RTL and testbench

GAME_TIMER_CTRL -- requirements
Module: game_timer_ctrl

---
 rtl/game_timer_ctrl.sv | 175 +++++++++++++++++
 tb/tb_game_timer_ctrl.sv | 263 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/game_timer_ctrl.sv
// game_timer_ctrl: maze game run timer with pause, BCD elapsed-seconds count
// and best-time record keeping.
//
// Ports
//   ClockIn     in   1   system clock, rising edge
//   nReset      in   1   synchronous, active-low reset
//   start       in   1   pulse: begin a new run with a cleared count
//   pause       in   1   pulse: toggle RUN <-> PAUSED
//   win         in   1   pulse: player reached the exit
//   clear_best  in   1   pulse: erase the stored best time
//   state       out  2   00 IDLE, 01 RUN, 10 PAUSED, 11 DONE
//   running     out  1   high when state is RUN
//   tick        out  1   one-cycle pulse per elapsed second in RUN (combinational)
//   bcd_time    out  24  elapsed seconds, 6 packed BCD digits, digit0 in [3:0]
//   best_time   out  24  lowest completed time, same packing
//   best_valid  out  1   best_time holds a recorded value
//   new_record  out  1   one-cycle pulse after best_time was updated
//   overflow    out  1   sticky: count saturated at 999999
module game_timer_ctrl #(
  parameter int unsigned TICK_DIV = 50000000
) (
  input  logic        ClockIn,
  input  logic        nReset,
  input  logic        start,
  input  logic        pause,
  input  logic        win,
  input  logic        clear_best,
  output logic [1:0]  state,
  output logic        running,
  output logic        tick,
  output logic [23:0] bcd_time,
  output logic [23:0] best_time,
  output logic        best_valid,
  output logic        new_record,
  output logic        overflow
);

  localparam int unsigned DIV_W  = 27;
  localparam int unsigned DIGITS = 6;
  localparam int unsigned TIME_W = 4 * DIGITS;
  localparam logic [DIV_W-1:0]  DIV_MAX  = DIV_W'(TICK_DIV - 1);
  localparam logic [TIME_W-1:0] TIME_MAX = 24'h999999;

  typedef enum logic [1:0] {
    S_IDLE   = 2'b00,
    S_RUN    = 2'b01,
    S_PAUSED = 2'b10,
    S_DONE   = 2'b11
  } state_t;

  state_t            r_state;
  state_t            w_state_next;
  logic [DIV_W-1:0]  r_div;
  logic [TIME_W-1:0] r_bcd_time;
  logic [TIME_W-1:0] r_best_time;
  logic              r_best_valid;
  logic              r_new_record;
  logic              r_overflow;

  logic              w_tick;
  logic              w_win_acc;
  logic              w_at_max;
  logic              w_record;
  logic [TIME_W-1:0] w_bcd_inc;

  // Second boundary: divider at its last count while running.
  assign w_tick    = (r_state == S_RUN) && (r_div == DIV_MAX);
  // win only counts in RUN and only when start is not also present.
  assign w_win_acc = !start && win && (r_state == S_RUN);
  assign w_at_max  = (r_bcd_time == TIME_MAX);
  // Packed BCD orders like the decimal value, so a plain compare suffices.
  assign w_record  = w_win_acc && (!r_best_valid || (r_bcd_time < r_best_time));

  // State register.
  always_ff @(posedge ClockIn) begin
    if (!nReset) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_state_next;
    end
  end

  // Next-state logic; start beats win beats pause.
  always_comb begin
    w_state_next = r_state;
    if (start) begin
      w_state_next = S_RUN;
    end else begin
      case (r_state)
        S_RUN: begin
          if (win) begin
            w_state_next = S_DONE;
          end else if (pause) begin
            w_state_next = S_PAUSED;
          end
        end
        S_PAUSED: begin
          if (pause) begin
            w_state_next = S_RUN;
          end
        end
        default: w_state_next = r_state;
      endcase
    end
  end

  // Decimal +1 with ripple carry across the six digits.
  always_comb begin
    logic v_carry;
    w_bcd_inc = r_bcd_time;
    v_carry   = 1'b1;
    for (int i = 0; i < int'(DIGITS); i++) begin
      if (v_carry) begin
        if (r_bcd_time[4*i +: 4] == 4'd9) begin
          w_bcd_inc[4*i +: 4] = 4'd0;
        end else begin
          w_bcd_inc[4*i +: 4] = 4'(r_bcd_time[4*i +: 4] + 4'd1);
          v_carry             = 1'b0;
        end
      end
    end
  end

  // Divider, elapsed count and overflow; divider holds outside RUN.
  always_ff @(posedge ClockIn) begin
    if (!nReset) begin
      r_div      <= '0;
      r_bcd_time <= '0;
      r_overflow <= 1'b0;
    end else if (start) begin
      r_div      <= '0;
      r_bcd_time <= '0;
      r_overflow <= 1'b0;
    end else if (r_state == S_RUN) begin
      r_div <= w_tick ? '0 : DIV_W'(r_div + 1'b1);
      // The winning cycle freezes the pre-tick value.
      if (w_tick && !w_win_acc) begin
        if (w_at_max) begin
          r_overflow <= 1'b1;
        end else begin
          r_bcd_time <= w_bcd_inc;
        end
      end
    end
  end

  // Best-time record; clear_best overrides a coincident record.
  always_ff @(posedge ClockIn) begin
    if (!nReset) begin
      r_best_time  <= '0;
      r_best_valid <= 1'b0;
      r_new_record <= 1'b0;
    end else if (clear_best) begin
      r_best_time  <= '0;
      r_best_valid <= 1'b0;
      r_new_record <= 1'b0;
    end else if (w_record) begin
      r_best_time  <= r_bcd_time;
      r_best_valid <= 1'b1;
      r_new_record <= 1'b1;
    end else begin
      r_new_record <= 1'b0;
    end
  end

  assign state      = r_state;
  assign running    = (r_state == S_RUN);
  assign tick       = w_tick;
  assign bcd_time   = r_bcd_time;
  assign best_time  = r_best_time;
  assign best_valid = r_best_valid;
  assign new_record = r_new_record;
  assign overflow   = r_overflow;

endmodule

// File: tb/tb_game_timer_ctrl.sv
// tb_game_timer_ctrl: directed table, hand sequences and random stimulus
// for game_timer_ctrl, checked against an integer-seconds reference model.
module tb_game_timer_ctrl;

  localparam int TD = 4;
  localparam int M_IDLE = 0, M_RUN = 1, M_PAUSED = 2, M_DONE = 3;

  logic        ClockIn = 1'b0;
  logic        nReset = 1'b0;
  logic        start = 1'b0, pause = 1'b0, win = 1'b0, clear_best = 1'b0;
  logic [1:0]  state;
  logic        running, tick, best_valid, new_record, overflow;
  logic [23:0] bcd_time, best_time;

  game_timer_ctrl #(.TICK_DIV(TD)) dut (
    .ClockIn(ClockIn), .nReset(nReset), .start(start), .pause(pause),
    .win(win), .clear_best(clear_best), .state(state), .running(running),
    .tick(tick), .bcd_time(bcd_time), .best_time(best_time),
    .best_valid(best_valid), .new_record(new_record), .overflow(overflow)
  );

  always #5 ClockIn = ~ClockIn;

  int checks = 0;
  int errors = 0;

  // Reference model: mode, phase within the second, whole seconds.
  int m_mode = 0, m_phase = 0, m_secs = 0, m_best = 0;
  bit m_bv = 0, m_nr = 0, m_ov = 0, mdl_ok = 0;

  typedef struct {
    logic rst, st, ps, wn, cb;
    logic [1:0]  e_state;
    logic [23:0] e_bcd, e_best;
    logic e_bv, e_nr;
  } vec_t;
  vec_t tbl[19];

  function automatic logic [23:0] to_bcd(input int v);
    logic [23:0] r;
    int p;
    r = '0;
    p = 1;
    for (int k = 0; k < 6; k++) begin
      r[4*k +: 4] = 4'((v / p) % 10);
      p = p * 10;
    end
    return r;
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%h required=%h (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic model_edge(input logic rst, st, ps, wn, cb);
    bit tk, wa;
    if (rst) begin
      m_mode = M_IDLE; m_phase = 0; m_secs = 0; m_best = 0;
      m_bv = 0; m_nr = 0; m_ov = 0; mdl_ok = 1;
      return;
    end
    tk = (m_mode == M_RUN) && (m_phase == TD - 1);
    wa = !st && wn && (m_mode == M_RUN);
    m_nr = 0;
    if (cb) begin
      m_best = 0; m_bv = 0;
    end else if (wa && (!m_bv || m_secs < m_best)) begin
      m_best = m_secs; m_bv = 1; m_nr = 1;
    end
    if (st) begin
      m_mode = M_RUN; m_phase = 0; m_secs = 0; m_ov = 0;
    end else begin
      if (m_mode == M_RUN) begin
        m_phase = (m_phase + 1) % TD;
        if (tk && !wa) begin
          if (m_secs == 999999) m_ov = 1;
          else m_secs = m_secs + 1;
        end
      end
      case (m_mode)
        M_RUN:    if (wn) m_mode = M_DONE; else if (ps) m_mode = M_PAUSED;
        M_PAUSED: if (ps) m_mode = M_RUN;
        default: ;
      endcase
    end
  endtask

  task automatic check_model();
    chk("state", 32'(state), 32'(m_mode));
    chk("running", 32'(running), 32'(m_mode == M_RUN));
    chk("tick", 32'(tick), 32'((m_mode == M_RUN) && (m_phase == TD - 1)));
    chk("bcd_time", 32'(bcd_time), 32'(to_bcd(m_secs)));
    chk("best_time", 32'(best_time), 32'(to_bcd(m_best)));
    chk("best_valid", 32'(best_valid), 32'(m_bv));
    chk("new_record", 32'(new_record), 32'(m_nr));
    chk("overflow", 32'(overflow), 32'(m_ov));
  endtask

  // One clock: drive at negedge, model the edge, re-check at next negedge.
  task automatic step(input logic rst, st, ps, wn, cb);
    nReset = !rst; start = st; pause = ps; win = wn; clear_best = cb;
    model_edge(rst, st, ps, wn, cb);
    @(posedge ClockIn);
    @(negedge ClockIn);
    nReset = 1'b1; start = 1'b0; pause = 1'b0; win = 1'b0; clear_best = 1'b0;
    if (mdl_ok) check_model();
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) step(0, 0, 0, 0, 0);
  endtask

  int nticks;

  initial begin
    //            rst st ps wn cb  state  bcd        best       bv nr
    tbl[0]  = '{1'b1,1'b0,1'b0,1'b0,1'b0, 2'd0, 24'h000000, 24'h000000, 1'b0, 1'b0};
    tbl[1]  = '{1'b0,1'b0,1'b0,1'b1,1'b0, 2'd0, 24'h000000, 24'h000000, 1'b0, 1'b0};
    tbl[2]  = '{1'b0,1'b0,1'b1,1'b0,1'b0, 2'd0, 24'h000000, 24'h000000, 1'b0, 1'b0};
    tbl[3]  = '{1'b0,1'b1,1'b0,1'b0,1'b0, 2'd1, 24'h000000, 24'h000000, 1'b0, 1'b0};
    tbl[4]  = '{1'b0,1'b0,1'b0,1'b0,1'b0, 2'd1, 24'h000000, 24'h000000, 1'b0, 1'b0};
    tbl[5]  = '{1'b0,1'b0,1'b0,1'b0,1'b0, 2'd1, 24'h000000, 24'h000000, 1'b0, 1'b0};
    tbl[6]  = '{1'b0,1'b0,1'b0,1'b0,1'b0, 2'd1, 24'h000000, 24'h000000, 1'b0, 1'b0};
    tbl[7]  = '{1'b0,1'b0,1'b0,1'b0,1'b0, 2'd1, 24'h000001, 24'h000000, 1'b0, 1'b0};
    tbl[8]  = '{1'b0,1'b0,1'b1,1'b0,1'b0, 2'd2, 24'h000001, 24'h000000, 1'b0, 1'b0};
    tbl[9]  = '{1'b0,1'b0,1'b0,1'b1,1'b0, 2'd2, 24'h000001, 24'h000000, 1'b0, 1'b0};
    tbl[10] = '{1'b0,1'b0,1'b1,1'b0,1'b0, 2'd1, 24'h000001, 24'h000000, 1'b0, 1'b0};
    tbl[11] = '{1'b0,1'b0,1'b0,1'b0,1'b0, 2'd1, 24'h000001, 24'h000000, 1'b0, 1'b0};
    tbl[12] = '{1'b0,1'b0,1'b0,1'b0,1'b0, 2'd1, 24'h000001, 24'h000000, 1'b0, 1'b0};
    tbl[13] = '{1'b0,1'b0,1'b0,1'b1,1'b0, 2'd3, 24'h000001, 24'h000001, 1'b1, 1'b1};
    tbl[14] = '{1'b0,1'b0,1'b0,1'b0,1'b0, 2'd3, 24'h000001, 24'h000001, 1'b1, 1'b0};
    tbl[15] = '{1'b0,1'b0,1'b1,1'b0,1'b0, 2'd3, 24'h000001, 24'h000001, 1'b1, 1'b0};
    tbl[16] = '{1'b0,1'b1,1'b1,1'b1,1'b0, 2'd1, 24'h000000, 24'h000001, 1'b1, 1'b0};
    tbl[17] = '{1'b0,1'b0,1'b0,1'b0,1'b1, 2'd1, 24'h000000, 24'h000000, 1'b0, 1'b0};
    tbl[18] = '{1'b1,1'b1,1'b0,1'b0,1'b0, 2'd0, 24'h000000, 24'h000000, 1'b0, 1'b0};

    @(negedge ClockIn);

    // Directed table.
    for (int i = 0; i < 19; i++) begin
      step(tbl[i].rst, tbl[i].st, tbl[i].ps, tbl[i].wn, tbl[i].cb);
      chk($sformatf("tbl%0d_state", i), 32'(state), 32'(tbl[i].e_state));
      chk($sformatf("tbl%0d_bcd", i), 32'(bcd_time), 32'(tbl[i].e_bcd));
      chk($sformatf("tbl%0d_best", i), 32'(best_time), 32'(tbl[i].e_best));
      chk($sformatf("tbl%0d_bv", i), 32'(best_valid), 32'(tbl[i].e_bv));
      chk($sformatf("tbl%0d_nr", i), 32'(new_record), 32'(tbl[i].e_nr));
    end

    // 40 running cycles give ten ticks.
    step(1, 0, 0, 0, 0);
    step(0, 1, 0, 0, 0);
    nticks = 0;
    for (int i = 0; i < 40; i++) begin
      if (tick) nticks++;
      step(0, 0, 0, 0, 0);
    end
    chk("run40_ticks", 32'(nticks), 32'd10);
    chk("run40_bcd", 32'(bcd_time), 32'h000010);
    chk("run40_running", 32'(running), 32'd1);

    // Decimal carry 99 -> 100.
    idle(89 * TD);
    chk("bcd_99", 32'(bcd_time), 32'h000099);
    idle(TD);
    chk("bcd_100", 32'(bcd_time), 32'h000100);

    // Saturation at 999999 (count preloaded while paused).
    step(0, 0, 1, 0, 0);
    force dut.r_bcd_time = 24'h999999;
    m_secs = 999999;
    step(0, 0, 0, 0, 0);
    release dut.r_bcd_time;
    step(0, 0, 0, 0, 0);
    chk("preload_bcd", 32'(bcd_time), 32'h999999);
    step(0, 0, 1, 0, 0);
    idle(TD);
    chk("sat_bcd", 32'(bcd_time), 32'h999999);
    chk("sat_ovf", 32'(overflow), 32'd1);
    step(0, 1, 0, 0, 0);
    chk("restart_bcd", 32'(bcd_time), 32'h000000);
    chk("restart_ovf", 32'(overflow), 32'd0);

    // Pause holds the partial second.
    step(1, 0, 0, 0, 0);
    step(0, 1, 0, 0, 0);
    idle(6);
    step(0, 0, 1, 0, 0);
    nticks = 0;
    for (int i = 0; i < 20; i++) begin
      if (tick) nticks++;
      step(0, 0, 0, 0, 0);
    end
    chk("paused_ticks", 32'(nticks), 32'd0);
    step(0, 0, 1, 0, 0);
    idle(2);
    chk("resume_bcd", 32'(bcd_time), 32'h000002);

    // Best-time record sequence: 12, 15, 9.
    step(0, 1, 0, 0, 0);
    idle(12 * TD);
    step(0, 0, 0, 1, 0);
    chk("win12_state", 32'(state), 32'd3);
    chk("win12_best", 32'(best_time), 32'h000012);
    chk("win12_nr", 32'(new_record), 32'd1);
    step(0, 0, 0, 0, 0);
    chk("win12_nr_off", 32'(new_record), 32'd0);
    step(0, 1, 0, 0, 0);
    idle(15 * TD);
    step(0, 0, 0, 1, 0);
    chk("win15_best", 32'(best_time), 32'h000012);
    chk("win15_nr", 32'(new_record), 32'd0);
    step(0, 1, 0, 0, 0);
    idle(9 * TD);
    step(0, 0, 0, 1, 0);
    chk("win9_best", 32'(best_time), 32'h000009);
    chk("win9_nr", 32'(new_record), 32'd1);
    // Equal time does not count as a record.
    step(0, 1, 0, 0, 0);
    idle(9 * TD);
    step(0, 0, 0, 1, 0);
    chk("win9eq_nr", 32'(new_record), 32'd0);

    // Win on the tick cycle freezes the pre-tick value.
    step(0, 1, 0, 0, 0);
    idle(TD - 1);
    chk("pre_win_tick", 32'(tick), 32'd1);
    step(0, 0, 0, 1, 0);
    chk("wintick_bcd", 32'(bcd_time), 32'h000000);
    chk("wintick_state", 32'(state), 32'd3);
    step(0, 1, 1, 1, 0);
    chk("swp_state", 32'(state), 32'd1);
    chk("swp_nr", 32'(new_record), 32'd0);

    // clear_best beats a qualifying win.
    idle(TD);
    step(0, 0, 0, 1, 1);
    chk("clrwin_bv", 32'(best_valid), 32'd0);
    chk("clrwin_nr", 32'(new_record), 32'd0);

    // Reset mid-run overrides start.
    step(0, 1, 0, 0, 0);
    idle(TD + 1);
    step(1, 1, 1, 1, 0);
    chk("rst_state", 32'(state), 32'd0);
    chk("rst_bcd", 32'(bcd_time), 32'd0);
    chk("rst_tick", 32'(tick), 32'd0);

    // Random stimulus against the model.
    for (int i = 0; i < 4000; i++) begin
      step($urandom_range(0, 199) == 0, $urandom_range(0, 39) == 0,
           $urandom_range(0, 11) == 0, $urandom_range(0, 14) == 0,
           $urandom_range(0, 59) == 0);
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
